// File: rtl/imm_gen_pipe_if.sv
// ----------------------------------------------------------------------------
// imm_gen_pipe_if
// Handshake bundle for imm_gen_pipe. It carries both channels:
//   input side  : in_valid, in_ready, instr[31:7], imm_sel, in_tag
//   output side : out_valid, out_ready, imm, out_tag
// Modports:
//   master : producer/consumer environment (decode drives input, execute
//            drives out_ready)
//   slave  : the immediate generator itself
// XLEN and TAG_W must match the parameters of the attached imm_gen_pipe.
// ----------------------------------------------------------------------------
interface imm_gen_pipe_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [24:0]       instr;
    logic [2:0]        imm_sel;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   imm;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, instr, imm_sel, in_tag, out_ready,
        input  in_ready, out_valid, imm, out_tag
    );

    modport slave (
        input  in_valid, instr, imm_sel, in_tag, out_ready,
        output in_ready, out_valid, imm, out_tag
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// ----------------------------------------------------------------------------
// imm_gen_pipe
// Buffered immediate generator for the decode stage. Each accepted entry
// (instr[31:7], imm_sel, tag) is decoded into an XLEN-wide immediate and
// queued in a DEPTH-entry FIFO; entries leave in order towards execute.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   flush  in   synchronous flush, drops every queued entry, beats push/pop
//   bus    slave modport of imm_gen_pipe_if (both valid/ready channels)
// Parameters:
//   XLEN  (32|64)  immediate width, sign extension fills [XLEN-1:32]
//   DEPTH (2^n>=2) FIFO entries
//   TAG_W          sideband tag width
// Build option:
//   IMM_GEN_ZIMM_EN  when defined, imm_sel 6 (csr zimm) and 7 (shamt) are
//                    decoded; otherwise those entries carry imm = 0.
// ----------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    imm_gen_pipe_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        FMT_I  = 3'd0,
        FMT_U  = 3'd1,
        FMT_S  = 3'd2,
        FMT_B  = 3'd3,
        FMT_J  = 3'd4,
        FMT_L  = 3'd5,
        FMT_Z  = 3'd6,
        FMT_SH = 3'd7
    } immFmt_e;

    logic [XLEN-1:0]  immMem [DEPTH];
    logic [TAG_W-1:0] tagMem [DEPTH];

    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] count;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    logic [31:7]      ins;
    immFmt_e          fmt;
    logic [31:0]      raw;
    logic             signBit;
    logic [XLEN-1:0]  immNext;

    // ------------------------------------------------------------------
    // Flow control: both handshake outputs come from the registered count
    // only, so there is no combinational ready->valid path.
    // ------------------------------------------------------------------
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    assign bus.in_ready  = ~full;
    assign bus.out_valid = ~empty;

    assign push = bus.in_valid & ~full  & ~flush;
    assign pop  = bus.out_ready & ~empty & ~flush;

    // ------------------------------------------------------------------
    // Immediate decode
    // ------------------------------------------------------------------
    assign ins = bus.instr;
    assign fmt = immFmt_e'(bus.imm_sel);

    // raw is the 32-bit immediate; signBit replicates into [XLEN-1:32].
    always_comb begin
        raw     = '0;
        signBit = 1'b0;
        unique case (fmt)
            FMT_I, FMT_L: begin
                raw     = {{20{ins[31]}}, ins[31:20]};
                signBit = ins[31];
            end
            FMT_U: begin
                raw     = {ins[31:12], 12'b0};
                signBit = ins[31];
            end
            FMT_S: begin
                raw     = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                signBit = ins[31];
            end
            FMT_B: begin
                raw     = {{19{ins[31]}}, ins[31], ins[7], ins[30:25],
                           ins[11:8], 1'b0};
                signBit = ins[31];
            end
            FMT_J: begin
                raw     = {{11{ins[31]}}, ins[31], ins[19:12], ins[20],
                           ins[30:21], 1'b0};
                signBit = ins[31];
            end
`ifdef IMM_GEN_ZIMM_EN
            FMT_Z: begin
                raw     = {27'b0, ins[19:15]};
                signBit = 1'b0;
            end
            FMT_SH: begin
                raw     = {26'b0, ins[25:20]};
                signBit = 1'b0;
            end
`else
            FMT_Z, FMT_SH: begin
                raw     = '0;
                signBit = 1'b0;
            end
`endif
            default: begin
                raw     = '0;
                signBit = 1'b0;
            end
        endcase
    end

    // Fill with the sign first, then overlay the low word; works for
    // XLEN=32 and XLEN=64 without a zero-width replication.
    always_comb begin
        immNext       = {XLEN{signBit}};
        immNext[31:0] = raw;
    end

    // ------------------------------------------------------------------
    // Storage: data only, no reset needed because out_valid masks it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            immMem[wrPtr] <= immNext;
            tagMem[wrPtr] <= bus.in_tag;
        end
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Outputs are forced to zero while empty, including immediately on an
    // asynchronous reset since count clears asynchronously.
    assign bus.imm     = empty ? '0 : immMem[rdPtr];
    assign bus.out_tag = empty ? '0 : tagMem[rdPtr];

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    countBound: assert property (@(posedge clk) disable iff (!rst_n)
        count <= CNT_W'(DEPTH));

    flushClears: assert property (@(posedge clk) disable iff (!rst_n)
        flush |=> (count == '0));

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ----------------------------------------------------------------------------
// tb_imm_gen_pipe
// Directed bench for imm_gen_pipe. Two instances: dutA (XLEN=32, DEPTH=2)
// carries most scenarios, dutB (XLEN=64, DEPTH=2) checks upper-word sign
// extension. Inputs are driven and outputs sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_imm_gen_pipe;
    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(4)) busA ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(4)) busB ();

    imm_gen_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(4)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (busA)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(4)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (busB)
    );

    int vecs = 0;
    int errs = 0;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idleAll();
        busA.in_valid  = 1'b0;
        busA.instr     = '0;
        busA.imm_sel   = '0;
        busA.in_tag    = '0;
        busA.out_ready = 1'b0;
        busB.in_valid  = 1'b0;
        busB.instr     = '0;
        busB.imm_sel   = '0;
        busB.in_tag    = '0;
        busB.out_ready = 1'b0;
    endtask

    task automatic offerA(input logic [2:0] sel, input logic [31:0] full,
                          input logic [3:0] tag);
        busA.in_valid = 1'b1;
        busA.imm_sel  = sel;
        busA.instr    = full[31:7];
        busA.in_tag   = tag;
    endtask

    task automatic offerB(input logic [2:0] sel, input logic [31:0] full,
                          input logic [3:0] tag);
        busB.in_valid = 1'b1;
        busB.imm_sel  = sel;
        busB.instr    = full[31:7];
        busB.in_tag   = tag;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b1;
        flush = 1'b0;
        idleAll();
        #2 rst_n = 1'b0;
        #1;
        vecs++;
        if (busA.out_valid !== 1'b0 || busA.in_ready !== 1'b1 ||
            busA.imm !== 32'h0 || busA.out_tag !== 4'h0) begin
            errs++;
            $display("FAIL reset_A: got v=%b r=%b imm=%h tag=%h want v=0 r=1 imm=0 tag=0",
                     busA.out_valid, busA.in_ready, busA.imm, busA.out_tag);
        end
        vecs++;
        if (busB.out_valid !== 1'b0 || busB.in_ready !== 1'b1 ||
            busB.imm !== 64'h0 || busB.out_tag !== 4'h0) begin
            errs++;
            $display("FAIL reset_B: got v=%b r=%b imm=%h tag=%h want v=0 r=1 imm=0 tag=0",
                     busB.out_valid, busB.in_ready, busB.imm, busB.out_tag);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_itype();
        offerA(3'd0, 32'hFFF00093, 4'h5);
        #1;
        vecs++;
        if (busA.out_valid !== 1'b0) begin
            errs++;
            $display("FAIL itype_no_bypass: got out_valid=%b want 0", busA.out_valid);
        end
        tick();
        busA.in_valid = 1'b0;
        vecs++;
        if (busA.out_valid !== 1'b1 || busA.imm !== 32'hFFFFFFFF || busA.out_tag !== 4'h5) begin
            errs++;
            $display("FAIL itype_head: got v=%b imm=%h tag=%h want v=1 imm=ffffffff tag=5",
                     busA.out_valid, busA.imm, busA.out_tag);
        end
        busA.out_ready = 1'b1;
        tick();
        busA.out_ready = 1'b0;
        vecs++;
        if (busA.out_valid !== 1'b0 || busA.imm !== 32'h0 || busA.out_tag !== 4'h0) begin
            errs++;
            $display("FAIL itype_drained: got v=%b imm=%h tag=%h want v=0 imm=0 tag=0",
                     busA.out_valid, busA.imm, busA.out_tag);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_utype64();
        offerB(3'd1, 32'h800000B7, 4'h1);
        tick();
        offerB(3'd1, 32'h123450B7, 4'h2);
        tick();
        busB.in_valid = 1'b0;
        vecs++;
        if (busB.imm !== 64'hFFFFFFFF_80000000 || busB.out_tag !== 4'h1) begin
            errs++;
            $display("FAIL utype_neg64: got imm=%h tag=%h want ffffffff80000000 tag=1",
                     busB.imm, busB.out_tag);
        end
        busB.out_ready = 1'b1;
        tick();
        vecs++;
        if (busB.imm !== 64'h00000000_12345000 || busB.out_tag !== 4'h2) begin
            errs++;
            $display("FAIL utype_pos64: got imm=%h tag=%h want 0000000012345000 tag=2",
                     busB.imm, busB.out_tag);
        end
        tick();
        busB.out_ready = 1'b0;
        vecs++;
        if (busB.out_valid !== 1'b0) begin
            errs++;
            $display("FAIL utype_drained: got out_valid=%b want 0", busB.out_valid);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_full();
        busA.out_ready = 1'b0;
        offerA(3'd0, 32'h00100093, 4'h1);
        tick();
        offerA(3'd0, 32'h00200093, 4'h2);
        tick();
        offerA(3'd0, 32'h00300093, 4'h3);
        #1;
        vecs++;
        if (busA.in_ready !== 1'b0 || busA.out_tag !== 4'h1 || busA.imm !== 32'h1) begin
            errs++;
            $display("FAIL full_block: got r=%b tag=%h imm=%h want r=0 tag=1 imm=1",
                     busA.in_ready, busA.out_tag, busA.imm);
        end
        tick();
        vecs++;
        if (busA.in_ready !== 1'b0 || busA.out_tag !== 4'h1 || busA.imm !== 32'h1) begin
            errs++;
            $display("FAIL full_hold: got r=%b tag=%h imm=%h want r=0 tag=1 imm=1",
                     busA.in_ready, busA.out_tag, busA.imm);
        end
        busA.out_ready = 1'b1;
        tick();
        vecs++;
        if (busA.in_ready !== 1'b1 || busA.out_tag !== 4'h2 || busA.imm !== 32'h2) begin
            errs++;
            $display("FAIL full_first_pop: got r=%b tag=%h imm=%h want r=1 tag=2 imm=2",
                     busA.in_ready, busA.out_tag, busA.imm);
        end
        tick();
        busA.in_valid = 1'b0;
        vecs++;
        if (busA.out_valid !== 1'b1 || busA.out_tag !== 4'h3 || busA.imm !== 32'h3 ||
            busA.in_ready !== 1'b1) begin
            errs++;
            $display("FAIL full_held_push: got v=%b r=%b tag=%h imm=%h want v=1 r=1 tag=3 imm=3",
                     busA.out_valid, busA.in_ready, busA.out_tag, busA.imm);
        end
        tick();
        busA.out_ready = 1'b0;
        vecs++;
        if (busA.out_valid !== 1'b0) begin
            errs++;
            $display("FAIL full_drained: got out_valid=%b want 0", busA.out_valid);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_push_pop();
        offerA(3'd0, 32'h00700093, 4'h6);
        tick();
        busA.in_valid = 1'b0;
        vecs++;
        if (busA.out_valid !== 1'b1 || busA.in_ready !== 1'b1 || busA.imm !== 32'h7) begin
            errs++;
            $display("FAIL pp_one_entry: got v=%b r=%b imm=%h want v=1 r=1 imm=7",
                     busA.out_valid, busA.in_ready, busA.imm);
        end
        offerA(3'd3, 32'hFE000EE3, 4'h7);
        busA.out_ready = 1'b1;
        tick();
        busA.in_valid  = 1'b0;
        busA.out_ready = 1'b0;
        vecs++;
        if (busA.out_valid !== 1'b1 || busA.in_ready !== 1'b1 ||
            busA.imm !== 32'hFFFFFFFC || busA.out_tag !== 4'h7) begin
            errs++;
            $display("FAIL pp_count_kept: got v=%b r=%b imm=%h tag=%h want v=1 r=1 imm=fffffffc tag=7",
                     busA.out_valid, busA.in_ready, busA.imm, busA.out_tag);
        end
        busA.out_ready = 1'b1;
        tick();
        busA.out_ready = 1'b0;
        vecs++;
        if (busA.out_valid !== 1'b0) begin
            errs++;
            $display("FAIL pp_drained: got out_valid=%b want 0", busA.out_valid);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_flush();
        offerA(3'd0, 32'h00800093, 4'h8);
        tick();
        offerA(3'd0, 32'h00900093, 4'h9);
        tick();
        offerA(3'd0, 32'h00A00093, 4'hA);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        busA.in_valid = 1'b0;
        vecs++;
        if (busA.out_valid !== 1'b0 || busA.in_ready !== 1'b1 ||
            busA.imm !== 32'h0 || busA.out_tag !== 4'h0) begin
            errs++;
            $display("FAIL flush_empty: got v=%b r=%b imm=%h tag=%h want v=0 r=1 imm=0 tag=0",
                     busA.out_valid, busA.in_ready, busA.imm, busA.out_tag);
        end
        tick();
        vecs++;
        if (busA.out_valid !== 1'b0) begin
            errs++;
            $display("FAIL flush_push_dropped: got out_valid=%b want 0", busA.out_valid);
        end
        // Fresh entry after flush must appear alone at the head.
        offerA(3'd2, 32'hFE112E23, 4'hB);
        tick();
        busA.in_valid  = 1'b0;
        vecs++;
        if (busA.imm !== 32'hFFFFFFFC || busA.out_tag !== 4'hB || busA.in_ready !== 1'b1) begin
            errs++;
            $display("FAIL flush_restart: got imm=%h tag=%h r=%b want imm=fffffffc tag=b r=1",
                     busA.imm, busA.out_tag, busA.in_ready);
        end
        busA.out_ready = 1'b1;
        tick();
        busA.out_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_formats();
        logic [2:0]  selTab [6];
        logic [31:0] insTab [6];
        logic [31:0] expTab [6];
        selTab[0] = 3'd4; insTab[0] = 32'h8000006F; expTab[0] = 32'hFFF00000;
        selTab[1] = 3'd4; insTab[1] = 32'h0010006F; expTab[1] = 32'h00000800;
        selTab[2] = 3'd5; insTab[2] = 32'h7FF03003; expTab[2] = 32'h000007FF;
        selTab[3] = 3'd2; insTab[3] = 32'h00112023; expTab[3] = 32'h00000000;
`ifdef IMM_GEN_ZIMM_EN
        selTab[4] = 3'd6; insTab[4] = 32'h3402D073; expTab[4] = 32'h00000005;
        selTab[5] = 3'd7; insTab[5] = 32'h03F0D093; expTab[5] = 32'h0000003F;
`else
        selTab[4] = 3'd6; insTab[4] = 32'h3402D073; expTab[4] = 32'h00000000;
        selTab[5] = 3'd7; insTab[5] = 32'h03F0D093; expTab[5] = 32'h00000000;
`endif
        for (int i = 0; i < 6; i++) begin
            offerA(selTab[i], insTab[i], 4'(i + 1));
            tick();
            busA.in_valid = 1'b0;
            vecs++;
            if (busA.out_valid !== 1'b1 || busA.imm !== expTab[i] ||
                busA.out_tag !== 4'(i + 1)) begin
                errs++;
                $display("FAIL format_%0d: got v=%b imm=%h tag=%h want v=1 imm=%h tag=%h",
                         i, busA.out_valid, busA.imm, busA.out_tag, expTab[i], 4'(i + 1));
            end
            busA.out_ready = 1'b1;
            tick();
            busA.out_ready = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        logic [31:0] zExp;
`ifdef IMM_GEN_ZIMM_EN
        zExp = 32'h5;
`else
        zExp = 32'h0;
`endif
        offerA(3'd6, 32'h3402D073, 4'hC);
        tick();
        offerA(3'd0, 32'h00D00093, 4'hD);
        tick();
        busA.in_valid = 1'b0;
        vecs++;
        if (busA.out_valid !== 1'b1 || busA.imm !== zExp || busA.out_tag !== 4'hC) begin
            errs++;
            $display("FAIL zimm_head: got v=%b imm=%h tag=%h want v=1 imm=%h tag=c",
                     busA.out_valid, busA.imm, busA.out_tag, zExp);
        end
        #2 rst_n = 1'b0;
        #1;
        vecs++;
        if (busA.out_valid !== 1'b0 || busA.in_ready !== 1'b1 ||
            busA.imm !== 32'h0 || busA.out_tag !== 4'h0) begin
            errs++;
            $display("FAIL async_reset: got v=%b r=%b imm=%h tag=%h want v=0 r=1 imm=0 tag=0",
                     busA.out_valid, busA.in_ready, busA.imm, busA.out_tag);
        end
        tick();
        rst_n = 1'b1;
        tick();
        vecs++;
        if (busA.out_valid !== 1'b0) begin
            errs++;
            $display("FAIL reset_entries_lost: got out_valid=%b want 0", busA.out_valid);
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_itype();
        test_utype64();
        test_full();
        test_push_pop();
        test_flush();
        test_formats();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
